lcd_grid_renderer: RTL and testbench

- Parametrised successor to the fixed 10x10 game-table-to-LCD byte converter.
- Takes a flattened ROWS x COLS cell grid from the game controller and scales each cell to CELL_PX x CELL_PX pixels at a configurable offset, with an optional 1-pixel border and optional inversion.
- Streams one full 128x64 KS0108-style frame as page/column bytes to the LCD controller over a valid/ready handshake.
- Snapshots the grid per frame so mid-frame game updates never tear.

---
 rtl/lcd_grid_renderer.sv | 236 +++++++++++++++++++++++
 tb/tb_lcd_grid_renderer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_grid_renderer.sv
// lcd_grid_renderer: scales a ROWS x COLS cell grid into a 128x64 KS0108-style
// frame and streams it as page/column bytes over a valid/ready handshake.
// The grid and invert flag are snapshotted once per frame so game updates
// arriving mid-frame never tear the picture.
module lcd_grid_renderer #(
    parameter int ROWS    = 10,
    parameter int COLS    = 10,
    parameter int CELL_PX = 6,
    parameter int X_OFF   = 2,
    parameter int Y_OFF   = 2,
    parameter int BORDER  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ROWS*COLS-1:0] grid,
    input  logic                 refresh,
    input  logic                 continuous,
    input  logic                 invert,
    input  logic                 en_tran,
    output logic [7:0]           data_out,
    output logic                 data_valid,
    output logic [2:0]           page,
    output logic [6:0]           column,
    output logic                 frame_start,
    output logic                 frame_done,
    output logic                 busy
);

    localparam int GW = COLS * CELL_PX;
    localparam int GH = ROWS * CELL_PX;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int SW = (CELL_PX > 1) ? $clog2(CELL_PX) : 1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND, S_DONE} state_t;

    state_t          state_q;
    logic [COLS-1:0] snap_q [ROWS];
    logic            inv_q;
    logic            pend_q;
    logic [7:0]      data_q;
    logic            vld_q;
    logic [2:0]      page_q;
    logic [6:0]      col_q;
    logic            fs_q;
    logic            fd_q;
    logic            busy_q;
    // {cell, sub-pixel} of column col_q along x
    logic [CW+SW-1:0] xcnt_q;
    // {cell, sub-pixel} of the row just above the current page (y = 8*page-1)
    logic [RW+SW-1:0] yprev_q;

    logic [6:0]       nx_col_d;
    logic [2:0]       nx_page_d;
    logic [CW+SW-1:0] nx_xcnt_d;
    logic [RW+SW-1:0] nx_yprev_d;
    logic [7:0]       nx_byte_d;
    logic [RW+SW-1:0] ycur;
    logic [RW-1:0]    rcell;
    logic [CW-1:0]    ccell;
    logic             pix;
    int               px;
    int               py;
    logic             start_frame;

    // Advance the x counters to column x; they restart at the grid's left edge.
    function automatic logic [CW+SW-1:0] x_step(input int x, input logic [CW+SW-1:0] cur);
        logic [CW-1:0] c;
        logic [SW-1:0] s;
        c = cur[CW+SW-1:SW];
        s = cur[SW-1:0];
        if (x == X_OFF) begin
            c = '0;
            s = '0;
        end else if (s == SW'(CELL_PX - 1)) begin
            c = c + CW'(1);
            s = '0;
        end else begin
            s = s + SW'(1);
        end
        return {c, s};
    endfunction

    // Advance the y counters to row y; they restart at the grid's top edge.
    function automatic logic [RW+SW-1:0] y_step(input int y, input logic [RW+SW-1:0] cur);
        logic [RW-1:0] c;
        logic [SW-1:0] s;
        c = cur[RW+SW-1:SW];
        s = cur[SW-1:0];
        if (y == Y_OFF) begin
            c = '0;
            s = '0;
        end else if (s == SW'(CELL_PX - 1)) begin
            c = c + RW'(1);
            s = '0;
        end else begin
            s = s + SW'(1);
        end
        return {c, s};
    endfunction

    function automatic logic in_grid(input int x, input int y);
        return (x >= X_OFF) && (x < X_OFF + GW) && (y >= Y_OFF) && (y < Y_OFF + GH);
    endfunction

    function automatic logic on_border(input int x, input int y);
        logic vert;
        logic horz;
        vert = ((x == X_OFF - 1) || (x == X_OFF + GW)) && (y >= Y_OFF - 1) && (y <= Y_OFF + GH);
        horz = ((y == Y_OFF - 1) || (y == Y_OFF + GH)) && (x >= X_OFF - 1) && (x <= X_OFF + GW);
        return (BORDER != 0) && (vert || horz);
    endfunction

    assign start_frame = ((state_q == S_IDLE) || (state_q == S_DONE)) &&
                         (refresh || pend_q || continuous);

    // Position, axis counters and pixel byte of the next byte to present.
    always_comb begin
        nx_col_d   = 7'd0;
        nx_page_d  = 3'd0;
        nx_yprev_d = yprev_q;
        ycur       = yprev_q;
        if (state_q != S_LOAD) begin
            nx_col_d  = col_q + 7'd1;
            nx_page_d = page_q;
            if (col_q == 7'd127) begin
                nx_page_d = page_q + 3'd1;
                for (int b = 0; b < 8; b++) begin
                    ycur = y_step(int'(page_q) * 8 + b, ycur);
                end
                nx_yprev_d = ycur;
            end
        end
        nx_xcnt_d = x_step(int'(nx_col_d), xcnt_q);
        ccell     = nx_xcnt_d[CW+SW-1:SW];
        px        = int'(nx_col_d);
        ycur      = nx_yprev_d;
        nx_byte_d = 8'd0;
        rcell     = '0;
        py        = 0;
        pix       = 1'b0;
        for (int b = 0; b < 8; b++) begin
            py    = int'(nx_page_d) * 8 + b;
            ycur  = y_step(py, ycur);
            rcell = ycur[RW+SW-1:SW];
            if (in_grid(px, py)) begin
                pix = snap_q[rcell][ccell];
            end else begin
                pix = on_border(px, py);
            end
            nx_byte_d[b] = pix ^ inv_q;
        end
    end

    // Frame sequencer: snapshot, byte streaming with handshake, frame pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            data_q  <= 8'd0;
            vld_q   <= 1'b0;
            page_q  <= 3'd0;
            col_q   <= 7'd0;
            fs_q    <= 1'b0;
            fd_q    <= 1'b0;
            busy_q  <= 1'b0;
            inv_q   <= 1'b0;
            pend_q  <= 1'b0;
            xcnt_q  <= '0;
            yprev_q <= '0;
            for (int r = 0; r < ROWS; r++) begin
                snap_q[r] <= '0;
            end
        end else begin
            fs_q <= 1'b0;
            fd_q <= 1'b0;
            if (start_frame) begin
                for (int r = 0; r < ROWS; r++) begin
                    snap_q[r] <= grid[r*COLS +: COLS];
                end
                inv_q   <= invert;
                page_q  <= 3'd0;
                col_q   <= 7'd0;
                fs_q    <= 1'b1;
                pend_q  <= 1'b0;
                busy_q  <= 1'b1;
                state_q <= S_LOAD;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        busy_q <= 1'b0;
                    end
                    S_LOAD: begin
                        if (refresh) pend_q <= 1'b1;
                        data_q  <= nx_byte_d;
                        vld_q   <= 1'b1;
                        page_q  <= nx_page_d;
                        col_q   <= nx_col_d;
                        xcnt_q  <= nx_xcnt_d;
                        yprev_q <= nx_yprev_d;
                        state_q <= S_SEND;
                    end
                    S_SEND: begin
                        if (refresh) pend_q <= 1'b1;
                        if (en_tran) begin
                            if ((page_q == 3'd7) && (col_q == 7'd127)) begin
                                vld_q   <= 1'b0;
                                fd_q    <= 1'b1;
                                state_q <= S_DONE;
                            end else begin
                                data_q  <= nx_byte_d;
                                page_q  <= nx_page_d;
                                col_q   <= nx_col_d;
                                xcnt_q  <= nx_xcnt_d;
                                yprev_q <= nx_yprev_d;
                            end
                        end
                    end
                    S_DONE: begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign data_out    = data_q;
    assign data_valid  = vld_q;
    assign page        = page_q;
    assign column      = col_q;
    assign frame_start = fs_q;
    assign frame_done  = fd_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_lcd_grid_renderer.sv
// Testbench for lcd_grid_renderer: directed scenarios plus a pixel-level
// reference model that checks every presented byte against the frame image.
module tb_lcd_grid_renderer;

    localparam int ROWS    = 10;
    localparam int COLS    = 10;
    localparam int CELL_PX = 6;
    localparam int X_OFF   = 2;
    localparam int Y_OFF   = 2;
    localparam int BORDER  = 1;
    localparam int GW      = COLS * CELL_PX;
    localparam int GH      = ROWS * CELL_PX;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [ROWS*COLS-1:0] grid = '0;
    logic                 refresh = 1'b0;
    logic                 continuous = 1'b0;
    logic                 invert = 1'b0;
    logic                 en_tran = 1'b0;
    logic [7:0]           data_out;
    logic                 data_valid;
    logic [2:0]           page;
    logic [6:0]           column;
    logic                 frame_start;
    logic                 frame_done;
    logic                 busy;

    int checks = 0;
    int errors = 0;
    int fs_count = 0;
    int fd_count = 0;
    int bytes_cnt = 0;
    int last_bytes = 0;
    logic [7:0] frame_buf [1024];

    // monitor/model state
    logic                 in_frame = 1'b0;
    logic                 done_next = 1'b0;
    int                   idx = 0;
    logic [ROWS*COLS-1:0] prev_grid = '0;
    logic [ROWS*COLS-1:0] snap_m = '0;
    logic                 prev_inv = 1'b0;
    logic                 inv_m = 1'b0;
    logic [3:0]           pat = 4'b1001;

    lcd_grid_renderer #(
        .ROWS(ROWS), .COLS(COLS), .CELL_PX(CELL_PX),
        .X_OFF(X_OFF), .Y_OFF(Y_OFF), .BORDER(BORDER)
    ) dut (
        .clk(clk), .rst(rst), .grid(grid), .refresh(refresh),
        .continuous(continuous), .invert(invert), .en_tran(en_tran),
        .data_out(data_out), .data_valid(data_valid), .page(page),
        .column(column), .frame_start(frame_start), .frame_done(frame_done),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Pixel byte straight from the picture definition, using plain division.
    function automatic logic [7:0] model_byte(input logic [ROWS*COLS-1:0] g, input logic inv,
                                              input int pg, input int x);
        logic [7:0] r;
        int y;
        logic p;
        r = 8'd0;
        for (int b = 0; b < 8; b++) begin
            y = pg * 8 + b;
            p = 1'b0;
            if (x >= X_OFF && x < X_OFF + GW && y >= Y_OFF && y < Y_OFF + GH)
                p = g[((y - Y_OFF) / CELL_PX) * COLS + (x - X_OFF) / CELL_PX];
            else if (BORDER == 1 &&
                     ((((x == X_OFF - 1) || (x == X_OFF + GW)) && y >= Y_OFF - 1 && y <= Y_OFF + GH) ||
                      (((y == Y_OFF - 1) || (y == Y_OFF + GH)) && x >= X_OFF - 1 && x <= X_OFF + GW)))
                p = 1'b1;
            r[b] = p ^ inv;
        end
        return r;
    endfunction

    // Per-cycle compare against the model, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            in_frame  = 1'b0;
            done_next = 1'b0;
        end else begin
            if (frame_done === 1'b1) begin
                fd_count++;
                last_bytes = bytes_cnt;
            end
            if (done_next) begin
                chk("done_pulse", frame_done, 1);
                chk("done_vld_low", data_valid, 0);
                done_next = 1'b0;
            end else begin
                chk("no_spurious_done", frame_done, 0);
            end
            if (frame_start === 1'b1) begin
                fs_count++;
                bytes_cnt = 0;
                chk("load_vld_low", data_valid, 0);
                chk("load_busy", busy, 1);
                snap_m   = prev_grid;
                inv_m    = prev_inv;
                in_frame = 1'b1;
                idx      = 0;
            end else begin
                if (data_valid === 1'b1 && en_tran === 1'b1) bytes_cnt++;
                if (in_frame) begin
                    chk("send_vld", data_valid, 1);
                    chk("send_busy", busy, 1);
                    chk("send_page", page, idx / 128);
                    chk("send_col", column, idx % 128);
                    chk("send_byte", data_out, model_byte(snap_m, inv_m, idx / 128, idx % 128));
                    if (en_tran === 1'b1 && data_valid === 1'b1) begin
                        frame_buf[idx] = data_out;
                        idx++;
                        if (idx == 1024) begin
                            in_frame  = 1'b0;
                            done_next = 1'b1;
                        end
                    end
                end
            end
        end
        prev_grid = grid;
        prev_inv  = invert;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string name, input int budget, input bit toggle, output int k);
        k = 0;
        while (frame_done !== 1'b1 && k < budget) begin
            if (toggle) en_tran = pat[k % 4];
            tick(1);
            k++;
        end
        en_tran = 1'b1;
        if (frame_done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s: frame_done not seen within %0d cycles", name, budget);
        end
    endtask

    task automatic pulse_refresh();
        refresh = 1'b1;
        tick(1);
        refresh = 1'b0;
    endtask

    initial begin
        int k;
        int fs0;
        int fd0;
        tick(3);
        // reset state
        chk("rst_data", data_out, 0);
        chk("rst_vld", data_valid, 0);
        chk("rst_page", page, 0);
        chk("rst_col", column, 0);
        chk("rst_fs", frame_start, 0);
        chk("rst_fd", frame_done, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        en_tran = 1'b1;
        tick(2);

        // reset mid-SEND aborts with no frame_done
        grid = '0;
        pulse_refresh();
        tick(40);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("abort_vld", data_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_page", page, 0);
        chk("abort_col", column, 0);
        fd0 = fd_count;
        tick(5);
        chk("abort_no_done", fd_count - fd0, 0);
        chk("abort_idle_busy", busy, 0);

        // empty grid, full throughput
        grid = '0;
        fd0 = fd_count;
        pulse_refresh();
        chk("t2_fs", frame_start, 1);
        chk("t2_load_vld", data_valid, 0);
        tick(1);
        chk("t2_first_vld", data_valid, 1);
        chk("t2_fs_gone", frame_start, 0);
        wait_done("t2", 2000, 1'b0, k);
        chk("t2_cycles", k, 1024);
        tick(1);
        chk("t2_busy_after", busy, 0);
        chk("t2_done_once", fd_count - fd0, 1);
        chk("t2_p0c0", frame_buf[0], 8'h00);
        chk("t2_p0c1", frame_buf[1], 8'hFE);
        chk("t2_p0c2", frame_buf[2], 8'h02);
        chk("t2_p7c1", frame_buf[7*128+1], 8'h7F);
        tick(2);

        // single cell at top-left
        grid = '0;
        grid[0] = 1'b1;
        pulse_refresh();
        wait_done("t3", 2000, 1'b0, k);
        for (int c = 2; c < 8; c++) chk($sformatf("t3_p0c%0d", c), frame_buf[c], 8'hFE);
        chk("t3_p0c8", frame_buf[8], 8'h02);
        chk("t3_p0c62", frame_buf[62], 8'hFE);
        tick(2);

        // en_tran stalls: 1,0,0,1
        grid = '0;
        grid[11] = 1'b1;
        grid[98] = 1'b1;
        pulse_refresh();
        wait_done("t4", 5000, 1'b1, k);
        tick(1);
        chk("t4_bytes", last_bytes, 1024);
        tick(2);

        // mid-frame refreshes + grid change: old picture, then one new frame
        grid = '0;
        grid[0] = 1'b1;
        pulse_refresh();
        tick(100);
        grid = '0;
        grid[99] = 1'b1;
        pulse_refresh();
        tick(200);
        pulse_refresh();
        wait_done("t5a", 2000, 1'b0, k);
        chk("t5_old_p0c2", frame_buf[2], 8'hFE);
        fs0 = fs_count;
        tick(1);
        chk("t5_restart", frame_start, 1);
        wait_done("t5b", 2000, 1'b0, k);
        chk("t5_new_p0c2", frame_buf[2], 8'h02);
        chk("t5_new_p7c56", frame_buf[7*128+56], 8'h7F);
        chk("t5_new_p7c61", frame_buf[7*128+61], 8'h7F);
        tick(20);
        chk("t5_one_extra", fs_count - fs0, 1);
        chk("t5_idle_busy", busy, 0);

        // continuous + invert
        grid = '0;
        fs0 = fs_count;
        fd0 = fd_count;
        invert = 1'b1;
        continuous = 1'b1;
        wait_done("t6a", 2000, 1'b0, k);
        chk("t6_p0c0", frame_buf[0], 8'hFF);
        chk("t6_p0c2", frame_buf[2], 8'hFD);
        tick(1);
        chk("t6_back2back", frame_start, 1);
        invert = 1'b0;
        tick(10);
        continuous = 1'b0;
        wait_done("t6b", 2000, 1'b0, k);
        chk("t6_f2_p0c0", frame_buf[0], 8'hFF);
        tick(1);
        chk("t6_no_restart", frame_start, 0);
        tick(5);
        chk("t6_busy", busy, 0);
        chk("t6_starts", fs_count - fs0, 2);
        chk("t6_dones", fd_count - fd0, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
